// File: rtl/jtcontra_prom_we.sv
// jtcontra_prom_we: splits the linear ROM download into SDRAM bank writes and colour PROM strobes.
// Optional JTCONTRA_PROM_CHECK_EN adds chksum, a 16-bit running sum of every accepted byte.
module jtcontra_prom_we #(
  parameter logic [24:0] SND_START  = 25'h02_8000,
  parameter logic [24:0] PCM_START  = 25'h03_0000,
  parameter logic [24:0] GFX1_START = 25'h04_8000,
  parameter logic [24:0] GFX2_START = 25'h0C_8000,
  parameter logic [24:0] PROM_START = 25'h12_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        sdram_ack,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  output logic        prom_we,
  output logic        dwnld_busy,
  output logic        overrun
`ifdef JTCONTRA_PROM_CHECK_EN
  ,
  output logic [15:0] chksum
`endif
);

  localparam logic [24:0] PROM_END = PROM_START + 25'd1024;

  typedef enum logic {IDLE, PEND} state_e;
  state_e state, state_nx;

  logic [24:0] off;
  logic [1:0]  dec_ba;
  logic        is_sdram, is_prom;
  logic [21:0] dec_addr;
  logic [1:0]  dec_mask;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the block can infer a latch.
    off      = ioctl_addr;
    dec_ba   = 2'd0;
    is_sdram = 1'b0;
    is_prom  = 1'b0;
    if (ioctl_addr < SND_START) begin
      is_sdram = 1'b1;
    end else if (ioctl_addr < PCM_START) begin
      off = ioctl_addr - SND_START;  dec_ba = 2'd1;  is_sdram = 1'b1;
    end else if (ioctl_addr < GFX1_START) begin
      // PCM follows the sound ROM inside bank 1
      off = ioctl_addr - PCM_START + (PCM_START - SND_START);  dec_ba = 2'd1;  is_sdram = 1'b1;
    end else if (ioctl_addr < GFX2_START) begin
      off = ioctl_addr - GFX1_START;  dec_ba = 2'd2;  is_sdram = 1'b1;
    end else if (ioctl_addr < PROM_START) begin
      off = ioctl_addr - GFX2_START;  dec_ba = 2'd3;  is_sdram = 1'b1;
    end else if (ioctl_addr < PROM_END) begin
      off = ioctl_addr - PROM_START;  is_prom = 1'b1;
    end
  end

  assign dec_addr = 22'(off >> 1);
  assign dec_mask = off[0] ? 2'b01 : 2'b10;

  logic wr_ok, sd_wr, pr_wr;
  assign wr_ok = ioctl_wr & downloading;
  assign sd_wr = wr_ok & is_sdram;
  assign pr_wr = wr_ok & is_prom;

  logic       def_pend;
  logic [9:0] def_addr;
  logic [7:0] def_data;
  logic       sd_take, pr_take, pr_defer, def_issue, drop;

  always_comb begin
    state_nx  = state;
    sd_take   = 1'b0;
    pr_take   = 1'b0;
    pr_defer  = 1'b0;
    def_issue = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: if (sd_wr) begin
        sd_take  = 1'b1;
        state_nx = PEND;
      end
      PEND: if (sdram_ack) begin
        if (sd_wr) sd_take = 1'b1;
        else       state_nx = IDLE;
      end else if (sd_wr) begin
        drop = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    // the PROM strobe reuses prog_addr/prog_data, so it waits while an SDRAM write is held
    if (pr_wr) begin
      if (def_pend)              drop     = 1'b1;
      else if (state_nx == IDLE) pr_take  = 1'b1;
      else                       pr_defer = 1'b1;
    end
    if (def_pend && state_nx == IDLE) def_issue = 1'b1;
  end

  logic dl_q, dl_rise;
  assign dl_rise = downloading & ~dl_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= '0;
      prog_ba   <= '0;
      prom_we   <= 1'b0;
      def_pend  <= 1'b0;
      def_addr  <= '0;
      def_data  <= '0;
      dl_q      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state   <= state_nx;
      prom_we <= pr_take | def_issue;
      dl_q    <= downloading;
      if (sd_take) begin
        prog_addr <= dec_addr;
        prog_data <= ioctl_data;
        prog_mask <= dec_mask;
        prog_ba   <= dec_ba;
      end else if (pr_take) begin
        prog_addr <= {12'd0, off[9:0]};
        prog_data <= ioctl_data;
      end else if (def_issue) begin
        prog_addr <= {12'd0, def_addr};
        prog_data <= def_data;
      end
      if (pr_defer) begin
        def_pend <= 1'b1;
        def_addr <= off[9:0];
        def_data <= ioctl_data;
      end else if (def_issue) begin
        def_pend <= 1'b0;
      end
      if (dl_rise)   overrun <= 1'b0;
      else if (drop) overrun <= 1'b1;
    end
  end

  assign prog_we    = (state == PEND);
  assign dwnld_busy = downloading | prog_we | def_pend;

`ifdef JTCONTRA_PROM_CHECK_EN
  logic [15:0] sum_base;
  assign sum_base = dl_rise ? 16'd0 : chksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              chksum <= '0;
    else if (sd_take | pr_take | pr_defer) chksum <= sum_base + {8'd0, ioctl_data};
    else                                  chksum <= sum_base;
  end
`endif

endmodule

// File: tb/tb_jtcontra_prom_we.sv
// Self-checking bench for jtcontra_prom_we: a negedge monitor pops expected SDRAM writes and
// PROM strobes from scoreboards; scenario tasks check timing, overrun, busy and reset inline.
module tb_jtcontra_prom_we;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        sdram_ack;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask, prog_ba;
  logic        prog_we, prom_we, dwnld_busy, overrun;
`ifdef JTCONTRA_PROM_CHECK_EN
  logic [15:0] chksum;
`endif

  jtcontra_prom_we dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .sdram_ack(sdram_ack), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_ba(prog_ba), .prog_we(prog_we), .prom_we(prom_we),
    .dwnld_busy(dwnld_busy), .overrun(overrun)
`ifdef JTCONTRA_PROM_CHECK_EN
    , .chksum(chksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [7:0]  data;
  } sd_t;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } pr_t;

  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
    sd_t         exp;
  } vec_t;

  sd_t sd_q[$];
  pr_t pr_q[$];
  int  checks = 0;
  int  errors = 0;

  // scoreboard monitor plus "held until acked" stability check
  logic hold_q = 1'b0;
  sd_t  held_q;
  always @(negedge clk) begin
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        checks++;
        if ({prog_we, prog_ba, prog_addr, prog_mask, prog_data} !== {1'b1, held_q}) begin
          errors++;
          $display("FAIL hold_stable: got we=%b %h expected we=1 %h", prog_we,
                   {prog_ba, prog_addr, prog_mask, prog_data}, held_q);
        end
      end
      if (prog_we && sdram_ack) begin
        checks++;
        if (sd_q.size() == 0) begin
          errors++;
          $display("FAIL sd_unexpected: got ba=%h addr=%h expected no write", prog_ba, prog_addr);
        end else begin
          sd_t e;
          e = sd_q.pop_front();
          if ({prog_ba, prog_addr, prog_mask, prog_data} !== e) begin
            errors++;
            $display("FAIL sd_write: got ba=%h addr=%h mask=%b data=%h expected ba=%h addr=%h mask=%b data=%h",
                     prog_ba, prog_addr, prog_mask, prog_data, e.ba, e.addr, e.mask, e.data);
          end
        end
      end
      if (prom_we) begin
        checks++;
        if (pr_q.size() == 0) begin
          errors++;
          $display("FAIL prom_unexpected: got addr=%h expected no strobe", prog_addr[9:0]);
        end else begin
          pr_t p;
          p = pr_q.pop_front();
          if ({prog_addr[9:0], prog_data} !== p) begin
            errors++;
            $display("FAIL prom_write: got addr=%h data=%h expected addr=%h data=%h",
                     prog_addr[9:0], prog_data, p.addr, p.data);
          end
        end
      end
      hold_q = prog_we && !sdram_ack;
      held_q = {prog_ba, prog_addr, prog_mask, prog_data};
    end
  end

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(posedge clk);
    #1 ioctl_wr = 1'b0;
  endtask

  task automatic do_ack();
    sdram_ack = 1'b1;
    @(posedge clk);
    #1 sdram_ack = 1'b0;
  endtask

  task automatic restart_download();
    downloading = 1'b0;
    @(posedge clk);
    #1 downloading = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
    ioctl_wr = 1'b0; sdram_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({prog_addr, prog_data, prog_mask, prog_ba, prog_we, prom_we, dwnld_busy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h data=%h mask=%b ba=%h we=%b prom=%b busy=%b ovr=%b expected all 0",
               prog_addr, prog_data, prog_mask, prog_ba, prog_we, prom_we, dwnld_busy, overrun);
    end
    rst = 1'b0;
    @(posedge clk);
    #1 downloading = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dwnld_busy !== 1'b1) begin
      errors++; $display("FAIL busy_downloading: got %b expected 1", dwnld_busy);
    end
  endtask

  task automatic test_main_byte();
    sd_q.push_back('{ba: 2'd0, addr: 22'h1, mask: 2'b01, data: 8'hA5});
    wr_byte(25'h00003, 8'hA5);
    checks++;
    if (prog_we !== 1'b1) begin errors++; $display("FAIL main_we_rise: got %b expected 1", prog_we); end
    repeat (2) @(posedge clk);
    #1 do_ack();
    checks++;
    if (prog_we !== 1'b0) begin errors++; $display("FAIL main_we_drop: got %b expected 0", prog_we); end
  endtask

  task automatic test_regions();
    vec_t tbl[$];
    tbl.push_back('{25'h030000, 8'h3C, '{2'd1, 22'h04000, 2'b10, 8'h3C}});
    tbl.push_back('{25'h028001, 8'h81, '{2'd1, 22'h00000, 2'b01, 8'h81}});
    tbl.push_back('{25'h027FFF, 8'h7F, '{2'd0, 22'h13FFF, 2'b01, 8'h7F}});
    tbl.push_back('{25'h047FFF, 8'h47, '{2'd1, 22'h0FFFF, 2'b01, 8'h47}});
    tbl.push_back('{25'h048002, 8'h48, '{2'd2, 22'h00001, 2'b10, 8'h48}});
    tbl.push_back('{25'h0C8007, 8'hC8, '{2'd3, 22'h00003, 2'b01, 8'hC8}});
    tbl.push_back('{25'h127FFF, 8'h12, '{2'd3, 22'h2FFFF, 2'b01, 8'h12}});
    foreach (tbl[i]) begin
      sd_q.push_back(tbl[i].exp);
      wr_byte(tbl[i].a, tbl[i].d);
      @(posedge clk);
      #1 do_ack();
      checks++;
      if (prog_we !== 1'b0) begin
        errors++; $display("FAIL region_we_drop[%0d]: got %b expected 0", i, prog_we);
      end
    end
  endtask

  task automatic test_prom();
    pr_q.push_back('{addr: 10'h105, data: 8'h0C});
    wr_byte(25'h128105, 8'h0C);
    checks++;
    if ({prom_we, prog_we} !== 2'b10) begin
      errors++; $display("FAIL prom_strobe: got prom_we=%b prog_we=%b expected 1 0", prom_we, prog_we);
    end
    @(posedge clk);
    #1;
    checks++;
    if (prom_we !== 1'b0) begin errors++; $display("FAIL prom_one_cycle: got %b expected 0", prom_we); end
    pr_q.push_back('{addr: 10'h3FF, data: 8'hE1});
    wr_byte(25'h1283FF, 8'hE1);
    @(posedge clk);
    #1 wr_byte(25'h128400, 8'h55);
    @(posedge clk);
    #1;
    checks++;
    if ({prom_we, prog_we} !== 2'b00) begin
      errors++; $display("FAIL prom_beyond: got prom_we=%b prog_we=%b expected 0 0", prom_we, prog_we);
    end
    downloading = 1'b0;
    wr_byte(25'h000010, 8'h11);
    checks++;
    if (prog_we !== 1'b0) begin errors++; $display("FAIL idle_ignore: got %b expected 0", prog_we); end
    downloading = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    sd_q.push_back('{ba: 2'd0, addr: 22'h8, mask: 2'b10, data: 8'h11});
    wr_byte(25'h000010, 8'h11);
    sd_q.push_back('{ba: 2'd0, addr: 22'h8, mask: 2'b01, data: 8'h22});
    sdram_ack = 1'b1;
    wr_byte(25'h000011, 8'h22);
    sdram_ack = 1'b0;
    checks++;
    if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, 22'h8, 2'b01, 8'h22}) begin
      errors++;
      $display("FAIL b2b_second: got we=%b addr=%h mask=%b data=%h expected we=1 addr=8 mask=01 data=22",
               prog_we, prog_addr, prog_mask, prog_data);
    end
    wr_byte(25'h000020, 8'h33);
    checks++;
    if ({overrun, prog_data} !== {1'b1, 8'h22}) begin
      errors++; $display("FAIL drop_overrun: got ovr=%b data=%h expected ovr=1 data=22", overrun, prog_data);
    end
    do_ack();
    downloading = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    downloading = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_deferred_prom();
    sd_q.push_back('{ba: 2'd0, addr: 22'h20, mask: 2'b10, data: 8'h44});
    wr_byte(25'h000040, 8'h44);
    pr_q.push_back('{addr: 10'h010, data: 8'h5A});
    wr_byte(25'h128010, 8'h5A);
    checks++;
    if ({prom_we, overrun} !== 2'b00) begin
      errors++; $display("FAIL defer_hold: got prom_we=%b ovr=%b expected 0 0", prom_we, overrun);
    end
    wr_byte(25'h128011, 8'h6B);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL defer_overrun: got %b expected 1", overrun); end
    do_ack();
    checks++;
    if ({prog_we, prom_we, prog_addr[9:0]} !== {2'b01, 10'h010}) begin
      errors++;
      $display("FAIL defer_issue: got we=%b prom_we=%b addr=%h expected 0 1 010", prog_we, prom_we, prog_addr[9:0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (prom_we !== 1'b0) begin errors++; $display("FAIL defer_one_cycle: got %b expected 0", prom_we); end
    restart_download();
  endtask

  task automatic test_end_of_download();
    sd_q.push_back('{ba: 2'd0, addr: 22'h28, mask: 2'b10, data: 8'h66});
    wr_byte(25'h000050, 8'h66);
    downloading = 1'b0;
    repeat (2) @(posedge clk);
    #1 sdram_ack = 1'b1;
    #1;
    checks++;
    if (dwnld_busy !== 1'b1) begin errors++; $display("FAIL busy_pending: got %b expected 1", dwnld_busy); end
    @(posedge clk);
    #1 sdram_ack = 1'b0;
    checks++;
    if ({dwnld_busy, prog_we} !== 2'b00) begin
      errors++; $display("FAIL busy_done: got busy=%b we=%b expected 0 0", dwnld_busy, prog_we);
    end
    downloading = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_pend();
    wr_byte(25'h000060, 8'h77);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (prog_we !== 1'b0) begin errors++; $display("FAIL async_reset: got %b expected 0", prog_we); end
    @(posedge clk);
    #1 rst = 1'b0;
    sdram_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (prog_we !== 1'b0) begin errors++; $display("FAIL post_reset_we[%0d]: got %b expected 0", i, prog_we); end
    end
    sdram_ack = 1'b0;
  endtask

`ifdef JTCONTRA_PROM_CHECK_EN
  task automatic test_chksum();
    restart_download();
    checks++;
    if (chksum !== 16'h0000) begin errors++; $display("FAIL chksum_clear: got %h expected 0000", chksum); end
    sd_q.push_back('{ba: 2'd0, addr: 22'h0, mask: 2'b10, data: 8'hFF});
    wr_byte(25'h000000, 8'hFF);
    do_ack();
    sd_q.push_back('{ba: 2'd0, addr: 22'h0, mask: 2'b01, data: 8'h02});
    wr_byte(25'h000001, 8'h02);
    do_ack();
    pr_q.push_back('{addr: 10'h105, data: 8'h0C});
    wr_byte(25'h128105, 8'h0C);
    @(posedge clk);
    #1;
    checks++;
    if (chksum !== 16'h010D) begin errors++; $display("FAIL chksum_sum: got %h expected 010D", chksum); end
  endtask
`endif

  initial begin
    test_reset();
    test_main_byte();
    test_regions();
    test_prom();
    test_back_to_back();
    test_deferred_prom();
    test_end_of_download();
    test_reset_pend();
`ifdef JTCONTRA_PROM_CHECK_EN
    test_chksum();
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sd_q.size() != 0 || pr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got sd=%0d prom=%0d left expected 0 0", sd_q.size(), pr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
